// File: rtl/breakout_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | breakout_pkg : shared Breakout constants, state codes and widths      |
// | Revision     : 1.0                                                    |
// +----------------------------------------------------------------------+
package breakout_pkg;

  localparam int SCREEN_W       = 640;
  localparam int SCREEN_H       = 480;
  localparam int BALL_SIZE      = 8;
  localparam int MISS_Y_DEFAULT = 470;
  localparam int SCORE_W        = 14;
  localparam int DIV_W          = 4;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SERVE    = 3'd1,
    ST_PLAY     = 3'd2,
    ST_MISS     = 3'd3,
    ST_GAMEOVER = 3'd4,
    ST_WIN      = 3'd5
  } state_t;

endpackage
`default_nettype wire

// File: rtl/frame_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_divider : loadable frame-tick divider, registered step pulse    |
// | Revision      : 1.0                                                   |
// +----------------------------------------------------------------------+
module frame_divider
  import breakout_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             count_en,
  input  logic             tick,
  input  logic [DIV_W-1:0] div,
  output logic             step_en
);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic             step_en_q, step_en_d;

  always_comb begin
    cnt_d     = cnt_q;
    step_en_d = 1'b0;
    if (load) begin
      cnt_d = '0;
    end else if (count_en && tick) begin
      // '>=' keeps the count sane if the divisor shrinks mid-count
      if (({1'b0, cnt_q} + 5'd1) >= {1'b0, div}) begin
        cnt_d     = '0;
        step_en_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      step_en_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      step_en_q <= step_en_d;
    end
  end

  assign step_en = step_en_q;

endmodule
`default_nettype wire

// File: rtl/breakout_game_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | breakout_game_ctrl : serve/play/miss/game-over/win sequencer          |
// | Option GAME_CTRL_SPEEDUP_EN: every 8th hit shortens the step divisor  |
// | Revision           : 1.0                                              |
// +----------------------------------------------------------------------+
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int SCREEN_H    = 480,
  parameter int MISS_Y      = MISS_Y_DEFAULT,
  parameter int LIVES_INIT  = 3,
  parameter int STEP_DIV    = 2,
  parameter int MISS_FRAMES = 60,
  parameter int POINTS      = 10
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               launch,
  input  logic [9:0]         ball_y,
  input  logic               brick_hit,
  input  logic               all_cleared,
  output logic               ball_reset,
  output logic               ball_step_en,
  output logic [1:0]         lives,
  output logic [SCORE_W-1:0] score,
  output logic [2:0]         state,
  output logic               game_over,
  output logic               win
);

  localparam int MISS_Y_EFF = (MISS_Y < SCREEN_H) ? MISS_Y : SCREEN_H - 1;
  localparam int PAUSE_W    = (MISS_FRAMES > 1) ? $clog2(MISS_FRAMES) : 1;

  state_t               state_q, state_d;
  logic                 launch_q;
  logic [1:0]           lives_q, lives_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [PAUSE_W-1:0]   pause_q, pause_d;
  logic                 ball_reset_q, ball_reset_d;
  logic                 game_over_q, game_over_d;
  logic                 win_q, win_d;
  logic [DIV_W-1:0]     div_eff;
  logic [SCORE_W:0]     score_sum;
  logic                 launch_rise;
  logic                 miss_fire;
  logic                 serve_start;

  assign launch_rise = launch & ~launch_q;
  assign serve_start = (state_q == ST_IDLE) && launch_rise;
  assign miss_fire   = (state_q == ST_PLAY) && !all_cleared && frame_tick &&
                       (ball_y >= 10'(MISS_Y_EFF));
  assign score_sum   = {1'b0, score_q} + (SCORE_W+1)'(POINTS);

  always_comb begin
    state_d = state_q;
    lives_d = lives_q;
    score_d = score_q;
    pause_d = pause_q;
    case (state_q)
      ST_IDLE: begin
        if (launch_rise) begin
          state_d = ST_SERVE;
          lives_d = 2'(LIVES_INIT);
          score_d = '0;
        end
      end
      ST_SERVE: begin
        if (launch_rise) state_d = ST_PLAY;
      end
      ST_PLAY: begin
        // a hit is scored even when the same cycle ends the rally
        if (brick_hit) begin
          score_d = score_sum[SCORE_W] ? SCORE_MAX : score_sum[SCORE_W-1:0];
        end
        if (all_cleared) begin
          state_d = ST_WIN;
        end else if (miss_fire) begin
          state_d = ST_MISS;
          lives_d = lives_q - 2'd1;
          pause_d = PAUSE_W'(MISS_FRAMES - 1);
        end
      end
      ST_MISS: begin
        if (frame_tick) begin
          if (pause_q == '0) begin
            state_d = (lives_q == 2'd0) ? ST_GAMEOVER : ST_SERVE;
          end else begin
            pause_d = pause_q - 1'b1;
          end
        end
      end
      ST_GAMEOVER, ST_WIN: begin
        if (launch_rise) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    ball_reset_d = !((state_d == ST_PLAY) || (state_d == ST_WIN));
    game_over_d  = (state_d == ST_GAMEOVER);
    win_d        = (state_d == ST_WIN);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      launch_q     <= 1'b1;
      lives_q      <= 2'd0;
      score_q      <= '0;
      pause_q      <= '0;
      ball_reset_q <= 1'b1;
      game_over_q  <= 1'b0;
      win_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      launch_q     <= launch;
      lives_q      <= lives_d;
      score_q      <= score_d;
      pause_q      <= pause_d;
      ball_reset_q <= ball_reset_d;
      game_over_q  <= game_over_d;
      win_q        <= win_d;
    end
  end

`ifdef GAME_CTRL_SPEEDUP_EN
  logic [2:0]       hit_cnt_q, hit_cnt_d;
  logic [DIV_W-1:0] div_q, div_d;

  always_comb begin
    hit_cnt_d = hit_cnt_q;
    div_d     = div_q;
    if (serve_start) begin
      hit_cnt_d = '0;
      div_d     = DIV_W'(STEP_DIV);
    end else if ((state_q == ST_PLAY) && brick_hit) begin
      hit_cnt_d = hit_cnt_q + 3'd1;
      if ((hit_cnt_q == 3'd7) && (div_q > 4'd1)) div_d = div_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      hit_cnt_q <= '0;
      div_q     <= DIV_W'(STEP_DIV);
    end else begin
      hit_cnt_q <= hit_cnt_d;
      div_q     <= div_d;
    end
  end

  assign div_eff = div_q;
`else
  assign div_eff = DIV_W'(STEP_DIV);
`endif

  frame_divider u_step_div (
    .clk      (clk),
    .reset    (reset),
    .load     (serve_start),
    .count_en ((state_q == ST_PLAY) && (state_d == ST_PLAY)),
    .tick     (frame_tick),
    .div      (div_eff),
    .step_en  (ball_step_en)
  );

  a_lives_no_underflow: assert property (
    @(posedge clk) disable iff (!reset) !(miss_fire && (lives_q == 2'd0))
  );

  assign ball_reset = ball_reset_q;
  assign lives      = lives_q;
  assign score      = score_q;
  assign state      = state_q;
  assign game_over  = game_over_q;
  assign win        = win_q;

endmodule
`default_nettype wire

// File: tb/tb_breakout_game_ctrl.sv
`default_nettype none
// Bench for breakout_game_ctrl: directed scenarios plus randomized play
// checked against a rule-level game model.
module tb_breakout_game_ctrl;

  localparam int MISS_Y = 470, LIVES = 3, STEP_DIV = 2, MISS_FRAMES = 60;
  localparam int POINTS = 10, SMAX = 16383;

  logic        clk = 1'b0;
  logic        reset = 1'b0, frame_tick = 1'b0, launch = 1'b0;
  logic        brick_hit = 1'b0, all_cleared = 1'b0;
  logic [9:0]  ball_y = 10'd100;
  logic        ball_reset, ball_step_en, game_over, win;
  logic [1:0]  lives;
  logic [13:0] score;
  logic [2:0]  state;

  int checks = 0, errors = 0;

  int m_state, m_lives, m_score, m_ticks, m_div, m_hits, m_pause;
  bit m_step, m_prev_launch;

  breakout_game_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .launch(launch),
    .ball_y(ball_y), .brick_hit(brick_hit), .all_cleared(all_cleared),
    .ball_reset(ball_reset), .ball_step_en(ball_step_en), .lives(lives),
    .score(score), .state(state), .game_over(game_over), .win(win)
  );

  always #5 clk = ~clk;

  task automatic model_step();
    bit rise;
    m_step = 1'b0;
    if (!reset) begin
      m_state = 0; m_lives = 0; m_score = 0; m_ticks = 0; m_pause = 0;
      m_div = STEP_DIV; m_hits = 0; m_prev_launch = 1'b1;
      return;
    end
    rise = launch && !m_prev_launch;
    m_prev_launch = launch;
    case (m_state)
      0: if (rise) begin
        m_state = 1; m_lives = LIVES; m_score = 0; m_ticks = 0;
        m_div = STEP_DIV; m_hits = 0;
      end
      1: if (rise) m_state = 2;
      2: begin
        if (brick_hit) begin
          m_score = (m_score + POINTS > SMAX) ? SMAX : m_score + POINTS;
`ifdef GAME_CTRL_SPEEDUP_EN
          m_hits++;
          if (m_hits % 8 == 0 && m_div > 1) m_div--;
`endif
        end
        if (all_cleared) m_state = 5;
        else if (frame_tick && ball_y >= MISS_Y) begin
          m_state = 3; m_lives--; m_pause = MISS_FRAMES;
        end else if (frame_tick) begin
          m_ticks++;
          if (m_ticks >= m_div) begin m_step = 1'b1; m_ticks = 0; end
        end
      end
      3: if (frame_tick) begin
        m_pause--;
        if (m_pause == 0) m_state = (m_lives == 0) ? 4 : 1;
      end
      4, 5: if (rise) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  task automatic cyc(input bit t, input bit h);
    frame_tick = t; brick_hit = h;
    @(posedge clk);
    model_step();
    #1;
    frame_tick = 1'b0; brick_hit = 1'b0;
  endtask

  task automatic press();
    launch = 1'b1; cyc(0, 0);
    launch = 1'b0; cyc(0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0; launch = 1'b0; all_cleared = 1'b0; ball_y = 10'd100;
    cyc(0, 0); cyc(0, 0);
    reset = 1'b1;
    cyc(0, 0);
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (ball_reset !== 1'b1) begin errors++; $display("FAIL reset_ball_reset: got %0b expected 1", ball_reset); end
    checks++; if (lives !== 2'd0) begin errors++; $display("FAIL reset_lives: got %0d expected 0", lives); end
    checks++; if (score !== 14'd0) begin errors++; $display("FAIL reset_score: got %0d expected 0", score); end
    checks++; if (ball_step_en !== 1'b0 || game_over !== 1'b0 || win !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got step=%0b go=%0b win=%0b expected 0 0 0", ball_step_en, game_over, win);
    end
  endtask

  task automatic test_serve_play();
    launch = 1'b1; cyc(0, 0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL serve_state: got %0d expected 1", state); end
    checks++; if (lives !== 2'd3) begin errors++; $display("FAIL serve_lives: got %0d expected 3", lives); end
    cyc(0, 0);
    checks++; if (state !== 3'd1) begin errors++; $display("FAIL held_launch: got %0d expected 1", state); end
    launch = 1'b0; cyc(0, 0);
    press();
    checks++; if (state !== 3'd2 || ball_reset !== 1'b0) begin
      errors++; $display("FAIL play_state: got state=%0d ball_reset=%0b expected 2 0", state, ball_reset);
    end
    for (int i = 1; i <= 6; i++) begin
      cyc(1, 0);
      checks++; if (ball_step_en !== 1'(i % 2 == 0)) begin
        errors++; $display("FAIL step_tick%0d: got %0b expected %0b", i, ball_step_en, i % 2 == 0);
      end
      cyc(0, 0);
      checks++; if (ball_step_en !== 1'b0) begin errors++; $display("FAIL step_gap%0d: got %0b expected 0", i, ball_step_en); end
    end
    for (int i = 0; i < 30; i++) begin
      ball_y = 10'($urandom_range(0, MISS_Y - 1));
      cyc(1'($urandom_range(0, 1)), 0);
      checks++; if (ball_step_en !== m_step) begin
        errors++; $display("FAIL step_random: got %0b expected %0b", ball_step_en, m_step);
      end
    end
  endtask

  task automatic test_score();
    int guard;
    for (int i = 1; i <= 5; i++) cyc(0, 1);
    checks++; if (score !== 14'd50) begin errors++; $display("FAIL score_five_hits: got %0d expected 50", score); end
    for (int i = 0; i < 40; i++) begin
      ball_y = 10'($urandom_range(0, MISS_Y - 1));
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)));
      checks++; if (score !== 14'(m_score) || ball_step_en !== m_step) begin
        errors++; $display("FAIL score_random: got score=%0d step=%0b expected %0d %0b", score, ball_step_en, m_score, m_step);
      end
    end
    guard = 0;
    while (m_score < SMAX && guard < 2000) begin cyc(0, 1); guard++; end
    checks++; if (score !== 14'd16383) begin errors++; $display("FAIL score_saturate: got %0d expected 16383", score); end
    cyc(0, 1);
    checks++; if (score !== 14'd16383) begin errors++; $display("FAIL score_no_wrap: got %0d expected 16383", score); end
  endtask

  task automatic test_miss_gameover();
    for (int r = 0; r < 3; r++) begin
      ball_y = 10'(MISS_Y);
      cyc(1, 0);
      checks++; if (state !== 3'd3 || lives !== 2'(2 - r) || ball_reset !== 1'b1) begin
        errors++; $display("FAIL miss%0d: got state=%0d lives=%0d ball_reset=%0b expected 3 %0d 1", r, state, lives, ball_reset, 2 - r);
      end
      ball_y = 10'd200;
      for (int k = 1; k <= MISS_FRAMES; k++) begin
        repeat ($urandom_range(0, 2)) cyc(0, 0);
        cyc(1, 0);
        if (k == MISS_FRAMES - 1) begin
          checks++; if (state !== 3'd3) begin errors++; $display("FAIL miss_pause%0d: got %0d expected 3", r, state); end
        end
      end
      checks++; if (state !== 3'((r < 2) ? 1 : 4)) begin
        errors++; $display("FAIL miss_exit%0d: got %0d expected %0d", r, state, (r < 2) ? 1 : 4);
      end
      if (r < 2) press();
    end
    checks++; if (game_over !== 1'b1 || ball_reset !== 1'b1) begin
      errors++; $display("FAIL gameover_flags: got go=%0b ball_reset=%0b expected 1 1", game_over, ball_reset);
    end
  endtask

  task automatic test_win();
    press();
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL gameover_to_idle: got %0d expected 0", state); end
    press();
    checks++; if (score !== 14'd0 || lives !== 2'd3) begin
      errors++; $display("FAIL restart: got score=%0d lives=%0d expected 0 3", score, lives);
    end
    press();
    cyc(0, 1); cyc(0, 1);
    all_cleared = 1'b1; ball_y = 10'(MISS_Y);
    cyc(1, 1);
    all_cleared = 1'b0; ball_y = 10'd100;
    checks++; if (state !== 3'd5 || win !== 1'b1 || ball_reset !== 1'b0) begin
      errors++; $display("FAIL win_state: got state=%0d win=%0b ball_reset=%0b expected 5 1 0", state, win, ball_reset);
    end
    checks++; if (lives !== 2'd3 || score !== 14'd30) begin
      errors++; $display("FAIL win_counts: got lives=%0d score=%0d expected 3 30", lives, score);
    end
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1);
      checks++; if (ball_step_en !== 1'b0 || state !== 3'd5 || score !== 14'd30) begin
        errors++; $display("FAIL win_frozen: got step=%0b state=%0d score=%0d expected 0 5 30", ball_step_en, state, score);
      end
    end
  endtask

  task automatic test_reset_midgame();
    press(); press(); press();
    cyc(0, 1); cyc(0, 1); cyc(0, 1);
    reset = 1'b0; cyc(0, 0);
    checks++; if (state !== 3'd0 || lives !== 2'd0 || score !== 14'd0) begin
      errors++; $display("FAIL midgame_reset: got state=%0d lives=%0d score=%0d expected 0 0 0", state, lives, score);
    end
    reset = 1'b1; cyc(0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 7) == 0) launch = ~launch;
      all_cleared = 1'($urandom_range(0, 63) == 0);
      ball_y = ($urandom_range(0, 15) == 0) ? 10'($urandom_range(MISS_Y, 479))
                                           : 10'($urandom_range(0, MISS_Y - 1));
      reset = 1'($urandom_range(0, 799) != 0);
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0));
      checks++; if (state !== 3'(m_state)) begin errors++; $display("FAIL rand_state@%0d: got %0d expected %0d", i, state, m_state); end
      checks++; if (lives !== 2'(m_lives)) begin errors++; $display("FAIL rand_lives@%0d: got %0d expected %0d", i, lives, m_lives); end
      checks++; if (score !== 14'(m_score)) begin errors++; $display("FAIL rand_score@%0d: got %0d expected %0d", i, score, m_score); end
      checks++; if (ball_step_en !== m_step) begin errors++; $display("FAIL rand_step@%0d: got %0b expected %0b", i, ball_step_en, m_step); end
      checks++; if (ball_reset !== 1'(!(m_state == 2 || m_state == 5)) || game_over !== 1'(m_state == 4) || win !== 1'(m_state == 5)) begin
        errors++; $display("FAIL rand_flags@%0d: got br=%0b go=%0b win=%0b for state %0d", i, ball_reset, game_over, win, m_state);
      end
    end
    reset = 1'b1; all_cleared = 1'b0;
  endtask

`ifdef GAME_CTRL_SPEEDUP_EN
  task automatic test_speedup();
    reset = 1'b0; launch = 1'b0; ball_y = 10'd100; cyc(0, 0);
    reset = 1'b1; cyc(0, 0);
    press(); press();
    for (int round = 0; round < 2; round++) begin
      repeat (8) cyc(0, 1);
      for (int i = 0; i < 4; i++) begin
        cyc(1, 0);
        checks++; if (ball_step_en !== 1'b1) begin
          errors++; $display("FAIL speedup_r%0d_t%0d: got %0b expected 1", round, i, ball_step_en);
        end
        cyc(0, 0);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_serve_play();
    test_score();
    test_miss_gameover();
    test_win();
    test_reset_midgame();
    test_random();
`ifdef GAME_CTRL_SPEEDUP_EN
    test_speedup();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
